// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode/funct encodings, FSM states and decode classes shared by alu_seq_ctrl.
package alu_seq_pkg;
    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_MUL   = 5'b11001;
    localparam logic [4:0] OP_SHIFT = 5'b11010;
    localparam logic [4:0] OP_ALU   = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;
    localparam logic [1:0] F_ADD  = 2'b00;
    localparam logic [1:0] F_SUB  = 2'b01;
    localparam logic [1:0] F_XOR  = 2'b10;
    localparam logic [1:0] F_ANDN = 2'b11;
    localparam logic [1:0] F_ROL  = 2'b00;
    localparam logic [1:0] F_SLL  = 2'b01;
    localparam logic [1:0] F_ROR  = 2'b10;
    localparam logic [1:0] F_SRL  = 2'b11;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SINGLE, SHIFT, MUL, ILLEGAL} op_class_t;
    typedef enum logic [3:0] {
        L_SUM, L_XOR, L_ANDN, L_SEQ, L_SLT, L_SLE, L_SCO, L_PASSA, L_PASSB, L_SLBI, L_ZERO
    } lsel_t;
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: maps {ALU_op,ALU_funct} to op class, adder controls and result select.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [4:0] op,
    input  logic [1:0] funct,
    output op_class_t  cls,
    output logic       inv_a,
    output logic       inv_b,
    output logic       cin,
    output lsel_t      lsel
);
    always_comb begin
        cls   = SINGLE;
        inv_a = 1'b0;
        inv_b = 1'b0;
        cin   = 1'b0;
        lsel  = L_ZERO;
        case (op)
            OP_ALU: begin
                lsel  = funct == F_XOR ? L_XOR : funct == F_ANDN ? L_ANDN : L_SUM;
                inv_a = funct == F_SUB;
                cin   = funct == F_SUB;
            end
            OP_ADDI:  lsel = L_SUM;
            OP_SUBI: begin
                lsel  = L_SUM;
                inv_a = 1'b1;
                cin   = 1'b1;
            end
            OP_SEQ:   lsel = L_SEQ;
            OP_SLT:   lsel = L_SLT;
            OP_SLE:   lsel = L_SLE;
            OP_SCO:   lsel = L_SCO;
            OP_LBI:   lsel = L_PASSB;
            OP_SLBI:  lsel = L_SLBI;
            OP_SHIFT: begin
                cls  = SHIFT;
                lsel = L_PASSA;
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:   cls = funct == 2'b00 ? MUL : ILLEGAL;
`endif
            OP_HALT:  lsel = L_ZERO;
            default:  cls = ILLEGAL;
        endcase
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: handshaked multi-cycle ALU (single-cycle ops, bit-serial shifts).
// Define ALU_SEQ_MUL_EN to add the shift-add multiplier (opcode 11001_00).
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALU_op,
    input  logic [1:0]       ALU_funct,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);
    localparam int HALF = WIDTH / 2;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             illegal_q, illegal_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [1:0]       funct_q, funct_d;
    op_class_t        cls;
    logic             inv_a, inv_b, cin;
    lsel_t            lsel;
    logic [WIDTH-1:0] a_in, b_in, alu_res, shifted;
    logic [WIDTH:0]   sum;

    alu_seq_decode u_dec (
        .op(ALU_op), .funct(ALU_funct), .cls(cls),
        .inv_a(inv_a), .inv_b(inv_b), .cin(cin), .lsel(lsel)
    );

    assign a_in = inv_a ? ~opA : opA;
    assign b_in = inv_b ? ~opB : opB;
    assign sum  = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        alu_res = '0;
        case (lsel)
            L_SUM:   alu_res = sum[WIDTH-1:0];
            L_XOR:   alu_res = opA ^ opB;
            L_ANDN:  alu_res = opA & ~opB;
            L_SEQ:   alu_res = {{(WIDTH-1){1'b0}}, opA == opB};
            L_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(opA) < $signed(opB)};
            L_SLE:   alu_res = {{(WIDTH-1){1'b0}}, $signed(opA) <= $signed(opB)};
            L_SCO:   alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
            L_PASSA: alu_res = opA;
            L_PASSB: alu_res = opB;
            L_SLBI:  alu_res = (opA << HALF) | {{HALF{1'b0}}, opB[HALF-1:0]};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        shifted = result_q;
        case (funct_q)
            F_ROL: shifted = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
            F_SLL: shifted = {result_q[WIDTH-2:0], 1'b0};
            F_ROR: shifted = {result_q[0], result_q[WIDTH-1:1]};
            F_SRL: shifted = {1'b0, result_q[WIDTH-1:1]};
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic             mul_q, mul_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        funct_d   = funct_q;
`ifdef ALU_SEQ_MUL_EN
        mul_d     = mul_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                funct_d   = ALU_funct;
                illegal_d = cls == ILLEGAL;
                result_d  = alu_res;
                state_d   = DONE;
                if (cls == SHIFT && opB[SHW-1:0] != '0) begin
                    state_d = BUSY;
                    cnt_d   = {1'b0, opB[SHW-1:0]};
                end
`ifdef ALU_SEQ_MUL_EN
                mul_d = cls == MUL;
                if (cls == MUL) begin
                    state_d  = BUSY;
                    cnt_d    = (SHW+1)'(WIDTH);
                    result_d = '0;
                    mcand_d  = opA;
                    mplier_d = opB;
                end
`endif
            end
            BUSY: begin
                cnt_d    = cnt_q - 1'b1;
                state_d  = cnt_q == (SHW+1)'(1) ? DONE : BUSY;
                result_d = shifted;
`ifdef ALU_SEQ_MUL_EN
                if (mul_q) begin
                    result_d = result_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
`endif
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            funct_q   <= '0;
`ifdef ALU_SEQ_MUL_EN
            mul_q     <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            funct_q   <= funct_d;
`ifdef ALU_SEQ_MUL_EN
            mul_q     <= mul_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
`endif
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign result    = result_q;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed self-checking bench for alu_seq_ctrl (WIDTH=16).
module tb_alu_seq_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, illegal;
    logic [4:0]   alu_op = '0;
    logic [1:0]   alu_funct = '0;
    logic [W-1:0] op_a = '0, op_b = '0, result;
    int           tests = 0, fails = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_op(alu_op), .ALU_funct(alu_funct), .opA(op_a), .opB(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [1:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        int n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("wait_in_ready", 0, 1);
        alu_op = op; alu_funct = f; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = ~a; op_b = ~b;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic op_chk(input string tag, input logic [4:0] op, input logic [1:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_r, input logic exp_i, input int exp_lat);
        int lat;
        issue(op, f, a, b, lat);
        chk({tag, "_res"}, 32'(result), 32'(exp_r));
        chk({tag, "_ill"}, 32'(illegal), 32'(exp_i));
        chk({tag, "_lat"}, lat, exp_lat);
        ack();
    endtask

    initial begin
        int  lat;
        bit  seen;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_illegal", illegal, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", in_ready, 1);

        op_chk("add",   5'b11011, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 0);
        op_chk("sub",   5'b11011, 2'b01, 16'h0005, 16'h0003, 16'hFFFE, 1'b0, 0);
        op_chk("xor",   5'b11011, 2'b10, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 0);
        op_chk("andn",  5'b11011, 2'b11, 16'hF0F0, 16'hFF00, 16'h00F0, 1'b0, 0);
        op_chk("seq1",  5'b11100, 2'b00, 16'h1234, 16'h1234, 16'h0001, 1'b0, 0);
        op_chk("seq0",  5'b11100, 2'b00, 16'h1234, 16'h1235, 16'h0000, 1'b0, 0);
        op_chk("slt1",  5'b11101, 2'b00, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 0);
        op_chk("slt0",  5'b11101, 2'b00, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 0);
        op_chk("sle_eq",5'b11110, 2'b00, 16'h0005, 16'h0005, 16'h0001, 1'b0, 0);
        op_chk("sle_gt",5'b11110, 2'b00, 16'hFFFF, 16'hFFFE, 16'h0000, 1'b0, 0);
        op_chk("sco1",  5'b11111, 2'b00, 16'h8000, 16'h8000, 16'h0001, 1'b0, 0);
        op_chk("sco0",  5'b11111, 2'b00, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 0);
        op_chk("lbi",   5'b11000, 2'b00, 16'h1111, 16'hBEEF, 16'hBEEF, 1'b0, 0);
        op_chk("slbi",  5'b10010, 2'b00, 16'h0012, 16'h3456, 16'h1256, 1'b0, 0);
        op_chk("addi",  5'b01000, 2'b00, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 0);
        op_chk("subi",  5'b10001, 2'b00, 16'h0002, 16'h0001, 16'hFFFF, 1'b0, 0);
        op_chk("halt",  5'b00000, 2'b00, 16'h1234, 16'h5678, 16'h0000, 1'b0, 0);
        op_chk("illop", 5'b00001, 2'b00, 16'h1234, 16'h5678, 16'h0000, 1'b1, 0);
        op_chk("ill_mf",5'b11001, 2'b01, 16'h1234, 16'h5678, 16'h0000, 1'b1, 0);

        op_chk("rol4",  5'b11010, 2'b00, 16'h8001, 16'h0004, 16'h0018, 1'b0, 4);
        op_chk("srl0",  5'b11010, 2'b11, 16'hABCD, 16'h0000, 16'hABCD, 1'b0, 0);
        op_chk("ror1",  5'b11010, 2'b10, 16'h0001, 16'h0001, 16'h8000, 1'b0, 1);
        op_chk("sll15", 5'b11010, 2'b01, 16'h0001, 16'h000F, 16'h8000, 1'b0, 15);
        op_chk("srl_hi",5'b11010, 2'b11, 16'h8000, 16'h0013, 16'h1000, 1'b0, 3);

        issue(5'b11010, 2'b00, 16'h0001, 16'h0003, lat);
        chk("busy_lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            alu_op = 5'b11011; alu_funct = 2'b00; op_a = 16'h1111; op_b = 16'h2222; in_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_result", result, 16'h0008);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        ack();
        chk("after_ack_in_ready", in_ready, 1);
        chk("after_ack_out_valid", out_valid, 0);
        op_chk("add_after", 5'b11011, 2'b00, 16'h0010, 16'h0020, 16'h0030, 1'b0, 0);

        alu_op = 5'b11010; alu_funct = 2'b01; op_a = 16'h0001; op_b = 16'h000A; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_busy_valid", out_valid, 0);
        chk("rst_busy_result", result, 0);
        chk("rst_busy_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rst_busy_no_valid", seen, 0);
        op_chk("add_post_rst", 5'b11011, 2'b00, 16'h0001, 16'h0002, 16'h0003, 1'b0, 0);

        issue(5'b11011, 2'b10, 16'h00FF, 16'h0F0F, lat);
        chk("pre_rst_done", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_done_valid", out_valid, 0);
        chk("rst_done_result", result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifdef ALU_SEQ_MUL_EN
        op_chk("mul",   5'b11001, 2'b00, 16'd300, 16'd300, 16'h5F90, 1'b0, 16);
`else
        op_chk("mul",   5'b11001, 2'b00, 16'd300, 16'd300, 16'h0000, 1'b1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; power of two, 4..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept request.
REQ-007 ALU_op  input  5  major opcode.
REQ-008 ALU_funct  input  2  function field.
REQ-009 opA  input  WIDTH  operand A (Rs).
REQ-010 opB  input  WIDTH  operand B (Rt / immediate / shift amount).
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  WIDTH  registered result.
REQ-014 illegal  output  1  registered; unsupported opcode flag, valid with out_valid.

Function
REQ-015 Request accepted on edge with in_valid && in_ready; operands, op, funct captured.
REQ-016 States: IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 Single-cycle ops, IDLE->DONE, out_valid one cycle after acceptance: 11011_00 ADD A+B; 11011_01 SUB B-A; 11011_10 XOR; 11011_11 ANDN A&~B; 11100 SEQ (A==B); 11101 SLT (A<B signed); 11110 SLE (A<=B signed); 11111 SCO carry-out of A+B; 11000 LBI pass B; 10010 SLBI (A<<8)|B[7:0] for WIDTH 16, (A<<WIDTH/2)|B[WIDTH/2-1:0] generally; 01000 ADDI A+B; 10001 SUBI B-A.
REQ-018 Set ops return 1 or 0 zero-extended to WIDTH; arithmetic wraps modulo 2^WIDTH.
REQ-019 Shift ops 11010_ff (00 ROL, 01 SLL, 10 ROR, 11 SRL), amount k = opB[SHW-1:0], one bit per BUSY cycle.
REQ-020 k=0: IDLE->DONE, result=A, latency 1; k>=1: IDLE->BUSY, counter=k, one shift per edge, decrement; edge with counter==1 -> DONE; latency k.
REQ-021 DONE holds result, illegal, out_valid stable until out_ready; on out_valid && out_ready edge -> IDLE.
REQ-022 No acceptance in BUSY or DONE; throughput one request per latency+1 cycles minimum.
REQ-023 Unlisted {ALU_op,ALU_funct}: IDLE->DONE, result=0, illegal=1, latency 1; 00000 HALT treated as legal, result=0.
REQ-024 Inputs in_valid/opA/opB ignored outside IDLE.

Reset
REQ-025 rst_n low: state=IDLE, out_valid=0, result=0, illegal=0, counter=0 immediately, independent of clk.
REQ-026 Reset mid-BUSY or mid-DONE discards operation; no out_valid afterward until new acceptance.
REQ-027 in_ready=1 while in reset and after release.

Configuration
REQ-028 Macro ALU_SEQ_MUL_EN defined: opcode 11001_00 MUL, shift-add, lower WIDTH bits of A*B, BUSY WIDTH cycles, latency WIDTH.
REQ-029 Macro undefined: 11001_00 handled as illegal per REQ-023; no multiplier logic synthesised.

Structure
REQ-030 Package alu_seq_pkg holds opcode/funct constants, state enum, op-class enum (SINGLE, SHIFT, MUL, ILLEGAL).
REQ-031 Sub-module alu_seq_decode: combinational {ALU_op,ALU_funct} -> op class, invA, invB, cin, logic select; instantiated once.
REQ-032 Shift counter width SHW+1 to cover MUL count WIDTH.

Verification
REQ-033 ADD opA=16'h7FFF opB=16'h0001 -> out_valid after 1 cycle, result=16'h8000, illegal=0.
REQ-034 ROL opA=16'h8001 opB=4 -> BUSY 4 cycles, result=16'h0018; SRL k=0 opA=16'hABCD -> result=16'hABCD, latency 1.
REQ-035 SLT opA=16'hFFFF opB=16'h0001 -> result=1; SCO opA=opB=16'h8000 -> result=1.
REQ-036 out_ready low 5 cycles in DONE -> result, out_valid stable, in_ready=0; accept after handshake.
REQ-037 rst_n low in cycle 2 of SLL k=10 -> out_valid=0, result=0 at once; next ADD completes normally.
REQ-038 MUL opA=16'd300 opB=16'd300 -> with ALU_SEQ_MUL_EN result=16'h5F90 after 16 cycles; without, illegal=1, result=0 after 1 cycle.
